flex_stp_word_sr: RTL and testbench

Parametrised serial-to-parallel shift register with word framing. It accumulates NUM_BITS accepted serial bits, selecting MSB-first or LSB-first order, and can skip stuffed bits. Each completed word transfers to a holding register and is offered downstream through a valid/ack handshake, with sticky overrun detection. It sits between the USB RX bit decoder/unstuffer and the RX packet FSM, replacing the bare shift register for byte assembly.

---
 rtl/flex_stp_word_sr.sv | 101 ++++++++++
 tb/tb_flex_stp_word_sr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/flex_stp_word_sr.sv
// Serial-to-parallel word assembler: accepts serial bits (minus stuffed ones),
// frames them into NUM_BITS words and hands each word off through a valid/ack holding register.
module flex_stp_word_sr #(
    parameter int NUM_BITS   = 8,
    parameter int SHIFT_MSB  = 1,
    parameter int RESET_ONES = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            shift_enable,
    input  logic                            serial_in,
    input  logic                            bit_skip,
    input  logic                            clear,
    input  logic                            word_ack,
    output logic [NUM_BITS-1:0]             parallel_out,
    output logic                            word_valid,
    output logic                            overrun,
    output logic [$clog2(NUM_BITS+1)-1:0]   bit_count,
    output logic [NUM_BITS-1:0]             shift_state
);
    localparam int CW = $clog2(NUM_BITS+1);
    localparam logic [CW-1:0]       LAST_IDX = CW'(NUM_BITS - 1);
    localparam logic [NUM_BITS-1:0] RST_PAT  = (RESET_ONES != 0) ? {NUM_BITS{1'b1}} : {NUM_BITS{1'b0}};

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_LAST  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [NUM_BITS-1:0] shift_q, shift_d, shifted;
    logic [NUM_BITS-1:0] pout_q, pout_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                accept, complete;

    assign accept   = shift_enable & ~bit_skip & ~clear;
    assign complete = accept & (state_q == ST_LAST);
    assign cnt_inc  = cnt_q + CW'(1);

    always_comb begin
        if (SHIFT_MSB != 0) shifted = {shift_q[NUM_BITS-2:0], serial_in};
        else                shifted = {serial_in, shift_q[NUM_BITS-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pout_d  = pout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clear) begin
            // realign framing; the holding register keeps its last word
            state_d = ST_ACCUM;
            cnt_d   = '0;
            shift_d = RST_PAT;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (accept) begin
                shift_d = shifted;
                if (state_q == ST_LAST) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                    pout_d  = shifted;
                    valid_d = 1'b1;
                    if (valid_q && !word_ack) ovr_d = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == LAST_IDX) ? ST_LAST : ST_ACCUM;
                end
            end
            // a completing word wins over an ack of the previous one
            if (!complete && word_ack) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            shift_q <= RST_PAT;
            pout_q  <= RST_PAT;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign parallel_out = pout_q;
    assign word_valid   = valid_q;
    assign overrun      = ovr_q;
    assign bit_count    = cnt_q;
    assign shift_state  = shift_q;
endmodule

// File: tb/tb_flex_stp_word_sr.sv
// Bench for flex_stp_word_sr: LSB-first and MSB-first instances share stimulus and
// are compared every cycle against a bit-history model, plus literal spot checks.
module tb_flex_stp_word_sr;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic shift_enable = 1'b0, serial_in = 1'b0, bit_skip = 1'b0, clear = 1'b0, word_ack = 1'b0;

    logic [NB-1:0] dl_pout, dl_shift, dm_pout, dm_shift;
    logic          dl_valid, dl_ovr, dm_valid, dm_ovr;
    logic [3:0]    dl_bc, dm_bc;

    always #5 clk = ~clk;

    flex_stp_word_sr #(.NUM_BITS(NB), .SHIFT_MSB(0), .RESET_ONES(1)) dut_lsb (
        .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .bit_skip(bit_skip), .clear(clear), .word_ack(word_ack),
        .parallel_out(dl_pout), .word_valid(dl_valid), .overrun(dl_ovr),
        .bit_count(dl_bc), .shift_state(dl_shift));

    flex_stp_word_sr #(.NUM_BITS(NB), .SHIFT_MSB(1), .RESET_ONES(1)) dut_msb (
        .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .bit_skip(bit_skip), .clear(clear), .word_ack(word_ack),
        .parallel_out(dm_pout), .word_valid(dm_valid), .overrun(dm_ovr),
        .bit_count(dm_bc), .shift_state(dm_shift));

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: history of accepted bits since reset/clear; words are read out of it.
    bit      hist[$];
    int      m_cnt;
    bit      m_valid, m_ovr;
    bit [NB-1:0] m_pout_l, m_pout_m;

    // k-th most recent bit (k=0 newest); missing history reads as idle ones
    function automatic bit recent(input int k);
        if (k < hist.size()) return hist[hist.size()-1-k];
        return 1'b1;
    endfunction

    // MSB-first: newest bit at bit 0. LSB-first: newest bit at the MSB.
    function automatic bit [NB-1:0] word_of(input bit lsb_first);
        bit [NB-1:0] w;
        for (int k = 0; k < NB; k++) begin
            if (lsb_first) w[NB-1-k] = recent(k);
            else           w[k]      = recent(k);
        end
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete(); m_cnt = 0; m_valid = 0; m_ovr = 0;
            m_pout_l = '1; m_pout_m = '1;
        end else if (clear) begin
            hist.delete(); m_cnt = 0; m_valid = 0; m_ovr = 0;
        end else begin
            if (shift_enable && !bit_skip) begin
                hist.push_back(serial_in);
                if (hist.size() > NB) void'(hist.pop_front());
                m_cnt++;
            end
            if (m_cnt == NB) begin
                m_cnt = 0;
                m_pout_l = word_of(1'b1);
                m_pout_m = word_of(1'b0);
                if (m_valid && !word_ack) m_ovr = 1;
                m_valid = 1;
            end else if (word_ack) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_pout_lsb",  dl_pout,  m_pout_l);
            chk("cmp_pout_msb",  dm_pout,  m_pout_m);
            chk("cmp_shift_lsb", dl_shift, word_of(1'b1));
            chk("cmp_shift_msb", dm_shift, word_of(1'b0));
            chk("cmp_valid",     {dl_valid, dm_valid}, {m_valid, m_valid});
            chk("cmp_overrun",   {dl_ovr, dm_ovr},     {m_ovr, m_ovr});
            chk("cmp_bitcount",  {dl_bc, dm_bc},       {4'(m_cnt), 4'(m_cnt)});
        end
    end

    task automatic cyc(input bit se, input bit sin, input bit skip, input bit clr, input bit ack);
        @(negedge clk);
        shift_enable = se; serial_in = sin; bit_skip = skip; clear = clr; word_ack = ack;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    // stream v bit 0 first; optionally ack alongside the final bit
    task automatic send(input logic [7:0] v, input bit ack_last);
        for (int i = 0; i < 8; i++) cyc(1, v[i], 0, 0, ack_last && (i == 7));
    endtask

    initial begin
        #1 rst = 1'b1;
        #12 cmp_en = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_pout", dl_pout, 8'hFF);
        chk("rst_shift", dl_shift, 8'hFF);
        chk("rst_valid", dl_valid, 0);

        // LSB-first / MSB-first byte
        send(8'h4D, 0); idle(1);
        chk("byte_lsb", dl_pout, 8'h4D);
        chk("byte_msb", dm_pout, 8'hB2);
        chk("byte_valid", dl_valid, 1);
        chk("byte_bc", dl_bc, 0);

        // valid holds without ack, drops after ack; stray ack ignored
        idle(10);
        chk("hold_valid", dl_valid, 1);
        cyc(0, 0, 0, 0, 1); idle(1);
        chk("ack_valid", dl_valid, 0);
        cyc(0, 0, 0, 0, 1); idle(1);

        // completion coincident with ack
        send(8'h4D, 0);
        send(8'hA5, 1); idle(1);
        chk("ackcomp_pout", dl_pout, 8'hA5);
        chk("ackcomp_valid", dl_valid, 1);
        chk("ackcomp_ovr", dl_ovr, 0);
        cyc(0, 0, 0, 0, 1); idle(1);

        // stuffed bit and gaps
        cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("skip_bc", dl_bc, 4);
        cyc(0, 1, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        idle(1);
        chk("skip_pout", dl_pout, 8'h4D);
        cyc(0, 0, 0, 0, 1); idle(1);

        // overrun
        send(8'h4D, 0);
        send(8'h3C, 0); idle(1);
        chk("ovr_pout", dl_pout, 8'h3C);
        chk("ovr_flag", dl_ovr, 1);
        chk("ovr_valid", dl_valid, 1);
        cyc(0, 0, 0, 0, 1); idle(2);
        chk("ovr_sticky", dm_ovr, 1);
        cyc(0, 0, 0, 1, 0); idle(1);
        chk("ovr_cleared", dl_ovr, 0);

        // clear mid-word
        for (int i = 0; i < 5; i++) cyc(1, i[0], 0, 0, 0);
        cyc(1, 1, 0, 1, 0); idle(1);
        chk("clr_bc", dl_bc, 0);
        chk("clr_shift", dm_shift, 8'hFF);
        chk("clr_pout", dl_pout, 8'h3C);
        send(8'h96, 0); idle(1);
        chk("clean_lsb", dl_pout, 8'h96);
        chk("clean_msb", dm_pout, 8'h69);

        // asynchronous reset mid-word
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_pout", dl_pout, 8'hFF);
        chk("arst_shift", dm_shift, 8'hFF);
        chk("arst_bc", dl_bc, 0);
        chk("arst_valid", {dl_valid, dl_ovr}, 0);
        @(negedge clk); rst = 1'b0;
        send(8'h4D, 0); idle(2);
        chk("post_rst_lsb", dl_pout, 8'h4D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
